// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- load/store unit between the decode controller and the
// data-memory bus.
//
// Accepts a load or store from the controller, runs one req/ack bus
// transaction, aligns store data onto byte lanes, and extracts and extends
// load data. The PC is held (stall) from acceptance until the access
// completes. A misaligned access is rejected in the same cycle and never
// reaches the bus.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   op_valid          instruction valid this cycle
//   ld_sel[2:0]       0 none, 1 lw, 2 lb, 3 lh, 4 lbu, 5 lhu, 6/7 lw
//   st_sel[1:0]       0 none, 1 sb, 2 sh, 3 sw (wins over ld_sel)
//   addr, wdata       byte address and store data
//   stall             hold PC / regfile write
//   done              one-cycle completion pulse, rdata_ext valid
//   rdata_ext         extended load result (0 for stores and aborts)
//   misalign          access rejected for alignment
//   bus_err           with done: access aborted by timeout
//   dmem_*            word-aligned request/ack bus towards data memory
//
// Parameters
//   TIMEOUT_CYCLES    REQ cycles allowed without ack; 0 waits forever
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  ld_sel,
    input  logic [1:0]  st_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Per-access context captured at acceptance; drives load extraction.
    typedef struct packed {
        logic       is_st;
        logic [1:0] size;
        logic       sext;
        logic [1:0] off;
    } acc_t;

    state_t           state;
    acc_t             acc;
    logic [CNT_W-1:0] cnt;

    // ---------------- decode of the presented instruction ----------------
    logic        is_st, is_ld, mem_op, aligned;
    logic [1:0]  dec_size;
    logic        dec_sext;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    always_comb begin
        is_st    = (st_sel != 2'd0);
        is_ld    = !is_st && (ld_sel != 3'd0);
        mem_op   = op_valid && (is_st || is_ld);
        dec_size = SZ_W;
        dec_sext = 1'b0;
        if (is_st) begin
            case (st_sel)
                2'd1:    dec_size = SZ_B;
                2'd2:    dec_size = SZ_H;
                default: dec_size = SZ_W;
            endcase
        end else begin
            case (ld_sel)
                3'd2:    begin dec_size = SZ_B; dec_sext = 1'b1; end
                3'd3:    begin dec_size = SZ_H; dec_sext = 1'b1; end
                3'd4:    dec_size = SZ_B;
                3'd5:    dec_size = SZ_H;
                default: dec_size = SZ_W;
            endcase
        end

        case (dec_size)
            SZ_H:    aligned = !addr[0];
            SZ_W:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        // Loads always fetch the whole word; lane selection happens on return.
        dec_be    = 4'hF;
        dec_wdata = wdata;
        if (is_st) begin
            case (dec_size)
                SZ_B: begin
                    dec_be    = 4'b0001 << addr[1:0];
                    dec_wdata = {4{wdata[7:0]}};
                end
                SZ_H: begin
                    dec_be    = 4'b0011 << addr[1:0];
                    dec_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    dec_be    = 4'hF;
                    dec_wdata = wdata;
                end
            endcase
        end
    end

    // Rejection and acceptance are only evaluated in IDLE; REQ/DONE own the
    // instruction already presented.
    always_comb begin
        misalign = (state == S_IDLE) && mem_op && !aligned;
        stall    = (state == S_REQ) || ((state == S_IDLE) && mem_op && aligned);
    end

    // ---------------- load data extraction ----------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_byte = dmem_rdata[8*acc.off +: 8];
        ld_half = acc.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (acc.size)
            SZ_B:    ld_ext = {{24{acc.sext & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_ext = {{16{acc.sext & ld_half[15]}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // ---------------- sequencing ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            done       <= 1'b0;
            bus_err    <= 1'b0;
            rdata_ext  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= '0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    if (mem_op && aligned) begin
                        acc.is_st  <= is_st;
                        acc.size   <= dec_size;
                        acc.sext   <= dec_sext;
                        acc.off    <= addr[1:0];
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_st;
                        dmem_be    <= dec_be;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_wdata <= dec_wdata;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    // An ack on the expiry cycle still completes normally.
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b0;
                        rdata_ext <= acc.is_st ? 32'h0 : ld_ext;
                        state     <= S_DONE;
                    end else if ((TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST)) begin
                        dmem_req  <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        rdata_ext <= 32'h0;
                        state     <= S_DONE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    bus_err <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
